// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin, burst-bounded arbiter that shares one FIFO write port among
// NUM_REQ producers. Per-producer handshake logic lives in fifo_wr_rr_lane.

module fifo_wr_rr_lane #(
    parameter int IDW = 2,
    parameter int IDX = 0
) (
    input  logic           burst,
    input  logic [IDW-1:0] owner,
    input  logic           valid,
    input  logic           fifo_full,
    output logic           ready,
    output logic           beat
);

    logic is_owner;

    assign is_owner = burst && (owner == IDW'(IDX));
    assign ready    = is_owner && !fifo_full;
    assign beat     = ready && valid;

endmodule

module fifo_wr_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_cs,
    output logic                       fifo_wr_enb,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                           state, state_nxt;
    logic   [IDW-1:0]                 grant_nxt;
    logic   [IDW-1:0]                 last_grant, last_nxt;
    logic   [CW-1:0]                  beat_cnt, cnt_nxt;
    logic   [NUM_REQ-1:0][WIDTH-1:0]  data_arr;
    logic   [NUM_REQ-1:0]             ready_vec;
    logic   [NUM_REQ-1:0]             beat_vec;
    logic                             burst;
    logic                             beat;
    logic                             owner_valid;
    logic                             pick_found;
    logic   [IDW-1:0]                 pick_idx;
    logic   [IDW-1:0]                 cand;

    assign data_arr    = req_data;
    assign burst       = rst && (state == BURST);
    assign beat        = |beat_vec;
    assign owner_valid = req_valid[grant_id];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_wr_rr_lane #(
            .IDW (IDW),
            .IDX (i)
        ) u_lane (
            .burst     (burst),
            .owner     (grant_id),
            .valid     (req_valid[i]),
            .fifo_full (fifo_full),
            .ready     (ready_vec[i]),
            .beat      (beat_vec[i])
        );
    end

    // Scan starts just past the last owner, so it wraps to 0 after NUM_REQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                    grant_nxt = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                // A stalled owner (valid && full) neither counts nor releases.
                if (!owner_valid) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_id;
                end else if (beat) begin
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                        last_nxt  = grant_id;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            fifo_cs    <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= cnt_nxt;
            fifo_cs    <= 1'b1;
        end
    end

    assign req_ready    = ready_vec;
    assign fifo_wr_enb  = beat;
    assign fifo_data_in = rst ? data_arr[grant_id] : '0;
    assign grant_valid  = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench for fifo_wr_rr_arbiter: constant-vector table, directed corner
// sequences, then randomized traffic against a behavioural model.

module tb_fifo_wr_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 4;
    localparam int IDW = 2;
    localparam logic [N*W-1:0] DATA0 = 32'h44332211;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             fifo_full = 1'b0;
    logic             fifo_cs;
    logic             fifo_wr_enb;
    logic [W-1:0]     fifo_data_in;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: owner = -1 while no burst is held.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;
    int m_gid   = 0;
    bit m_cs    = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_cs      (fifo_cs),
        .fifo_wr_enb  (fifo_wr_enb),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    typedef struct {
        logic         r;
        logic [N-1:0] v;
        logic         f;
        bit           gv;
        int           gid;
        bit           wr;
        bit           cs;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_owner = -1; m_last = N - 1; m_beats = 0; m_gid = 0; m_cs = 1'b0;
        end else begin
            m_cs = 1'b1;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (req_valid[i]) begin
                        m_owner = i; m_gid = i; m_beats = 0;
                        break;
                    end
                end
            end else if (!req_valid[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_last = m_owner; m_owner = -1;
                end
            end
        end
    endtask

    // One cycle: edge, model update, drive new inputs, wait to the sample point.
    task automatic tick(input logic r, input logic [N-1:0] v, input logic f, input logic [N*W-1:0] d);
        @(posedge clk);
        model_step();
        #1;
        rst = r; req_valid = v; fifo_full = f; req_data = d;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input bit gv, input int gid, input bit wr);
        logic [N-1:0] rdy;
        rdy = (gv && !fifo_full) ? N'(1 << gid) : '0;
        chk({tag, "_gv"}, grant_valid, gv);
        chk({tag, "_gid"}, grant_id, gid);
        chk({tag, "_wr"}, fifo_wr_enb, wr);
        chk({tag, "_rdy"}, req_ready, rdy);
        if (wr) chk({tag, "_data"}, fifo_data_in, req_data[gid*W +: W]);
    endtask

    task automatic check_model();
        bit ex_gv, ex_wr, ex_cs;
        int ex_gid;
        logic [N-1:0] ex_rdy;
        ex_gv = 1'b0; ex_wr = 1'b0; ex_cs = 1'b0; ex_gid = 0; ex_rdy = '0;
        if (rst) begin
            ex_cs  = m_cs;
            ex_gid = m_gid;
            if (m_owner >= 0) begin
                ex_gv = 1'b1;
                if (!fifo_full) ex_rdy = N'(1 << m_owner);
                ex_wr = req_valid[m_owner] && !fifo_full;
            end
        end
        chk("rnd_gv", grant_valid, ex_gv);
        chk("rnd_gid", grant_id, ex_gid);
        chk("rnd_cs", fifo_cs, ex_cs);
        chk("rnd_wr", fifo_wr_enb, ex_wr);
        chk("rnd_rdy", req_ready, ex_rdy);
        if (ex_wr) chk("rnd_data", fifo_data_in, req_data[m_owner*W +: W]);
        if (!rst) chk("rnd_rst_data", fifo_data_in, 0);
    endtask

    initial begin
        // Reset held 3 cycles with all requesters active, then five bursts.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 4'hF, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'hF, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < MB; j++)
                tbl[4 + 5*b + j] = '{1'b1, 4'hF, 1'b0, 1'b1, b % N, 1'b1, 1'b1};
            tbl[8 + 5*b] = '{1'b1, 4'hF, 1'b0, 1'b0, b % N, 1'b0, 1'b1};
        end
        for (int i = 0; i < 29; i++) begin
            tick(tbl[i].r, tbl[i].v, tbl[i].f, DATA0);
            expect_out($sformatf("rr%0d", i), tbl[i].gv, tbl[i].gid, tbl[i].wr);
            chk($sformatf("rr%0d_cs", i), fifo_cs, tbl[i].cs);
        end

        // Early release of requester 2, then 3 wins over 1; wrap from 3 to 0.
        tick(1'b0, 4'h0, 1'b0, DATA0);
        tick(1'b1, 4'b0100, 1'b0, DATA0); expect_out("er_idle", 0, 0, 0);
        tick(1'b1, 4'b0100, 1'b0, DATA0); expect_out("er_b1", 1, 2, 1);
        tick(1'b1, 4'b0100, 1'b0, DATA0); expect_out("er_b2", 1, 2, 1);
        tick(1'b1, 4'b0000, 1'b0, DATA0); expect_out("er_drop", 1, 2, 0);
        tick(1'b1, 4'b1010, 1'b0, DATA0); expect_out("er_gap", 0, 2, 0);
        for (int i = 0; i < MB; i++) begin
            tick(1'b1, 4'b1010, 1'b0, DATA0); expect_out("er_g3", 1, 3, 1);
        end
        tick(1'b1, 4'b1001, 1'b0, DATA0); expect_out("wr_gap", 0, 3, 0);
        for (int i = 0; i < MB; i++) begin
            tick(1'b1, 4'b1001, 1'b0, DATA0); expect_out("wr_g0", 1, 0, 1);
        end
        tick(1'b1, 4'b1000, 1'b0, DATA0); expect_out("wr_gap2", 0, 0, 0);
        tick(1'b1, 4'b1000, 1'b0, DATA0); expect_out("wr_g3", 1, 3, 1);

        // Full stall after the first beat; count must be held.
        tick(1'b0, 4'h0, 1'b0, DATA0);
        tick(1'b1, 4'b0001, 1'b0, DATA0); expect_out("fs_idle", 0, 0, 0);
        tick(1'b1, 4'b0001, 1'b0, DATA0); expect_out("fs_b1", 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'b0001, 1'b1, DATA0); expect_out("fs_stall", 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'b0001, 1'b0, DATA0); expect_out("fs_rest", 1, 0, 1);
        end
        tick(1'b1, 4'b0001, 1'b0, DATA0); expect_out("fs_end", 0, 0, 0);

        // Asynchronous reset in the middle of requester 1's second beat.
        tick(1'b0, 4'h0, 1'b0, DATA0);
        tick(1'b1, 4'b0010, 1'b0, DATA0); expect_out("ar_idle", 0, 0, 0);
        tick(1'b1, 4'b0010, 1'b0, DATA0); expect_out("ar_b1", 1, 1, 1);
        tick(1'b1, 4'b0010, 1'b0, DATA0); expect_out("ar_b2", 1, 1, 1);
        #1 rst = 1'b0;
        #1;
        expect_out("ar_in", 0, 0, 0);
        chk("ar_in_cs", fifo_cs, 0);
        chk("ar_in_data", fifo_data_in, 0);
        tick(1'b1, 4'hF, 1'b0, DATA0); expect_out("ar_rel", 0, 0, 0);
        chk("ar_rel_cs", fifo_cs, 0);
        tick(1'b1, 4'hF, 1'b0, DATA0); expect_out("ar_g0", 1, 0, 1);
        chk("ar_g0_cs", fifo_cs, 1);

        // Randomized traffic with producers honouring the hold-until-ready rule.
        tick(1'b0, 4'h0, 1'b0, DATA0);
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0]   acc, nv;
            logic [N*W-1:0] nd;
            acc = req_valid & req_ready;
            nv  = '0;
            nd  = req_data;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i] && $urandom_range(0, 15) != 0) begin
                    nv[i] = 1'b1;
                end else begin
                    nv[i] = ($urandom_range(0, 2) != 0);
                    nd[i*W +: W] = W'($urandom);
                end
            end
            tick(($urandom_range(0, 299) != 0), nv, ($urandom_range(0, 3) == 0), nd);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
